// File: rtl/bell_round_ctrl.sv
// Round sequencer for a two-player fruit-bell game: deals cards, judges presses, keeps scores.
// Define BELL_PENALTY_EN to make a wrong press also cost the presser one point (floor 0).
module bell_round_ctrl #(
    parameter int         WINDOW    = 32,
    parameter int         GAP       = 8,
    parameter int         WIN_SCORE = 5,
    parameter logic [7:0] SEED      = 8'hA5,
    parameter logic [3:0] KEY_P1    = 4'b1001,
    parameter logic [3:0] KEY_P2    = 4'b0111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] keypad_in,
    input  logic       key_valid,
    input  logic       load_en,
    input  logic [1:0] load_c,
    input  logic [2:0] load_n,
    output logic [1:0] c1,
    output logic [1:0] c2,
    output logic [2:0] n1,
    output logic [2:0] n2,
    output logic [2:0] score1,
    output logic [2:0] score2,
    output logic       hit,
    output logic       miss,
    output logic       who,
    output logic       game_over
);

    localparam int TMAX = (WINDOW > GAP) ? WINDOW : GAP;
    localparam int TW   = $clog2(TMAX) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_DEAL, S_WAIT, S_HOLD, S_OVER
    } state_t;

    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic [7:0]    lfsr_q;
    logic          ptr_q;
    logic          kv_q;
    logic [1:0]    c1_q, c2_q;
    logic [2:0]    n1_q, n2_q;
    logic [2:0]    score1_q, score2_q;
    logic [2:0]    score1_d, score2_d;
    logic          hit_q, miss_q, who_q, over_q;

    logic       fb;
    logic [1:0] rnd_c, deal_c;
    logic [2:0] rnd_n, deal_n;
    logic [3:0] sum;
    logic       right, press, pl, key_ok;

    assign fb     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign rnd_c  = (lfsr_q[1:0] == 2'd0) ? 2'd1 : lfsr_q[1:0];
    assign deal_c = load_en ? load_c : rnd_c;
    assign deal_n = load_en ? load_n : rnd_n;

    always_comb begin
        case (lfsr_q[4:2])
            3'd0, 3'd6: rnd_n = 3'd1;
            3'd7:       rnd_n = 3'd2;
            default:    rnd_n = lfsr_q[4:2];
        endcase
    end

    // Same fruit in both slots pools the counts; otherwise each slot stands alone
    assign sum   = {1'b0, n1_q} + {1'b0, n2_q};
    assign right = ((c1_q != 2'd0) && (c1_q == c2_q) && (sum == 4'd5)) ||
                   ((c1_q != 2'd0) && (c1_q != c2_q) && (n1_q == 3'd5)) ||
                   ((c2_q != 2'd0) && (c2_q != c1_q) && (n2_q == 3'd5));

    assign key_ok = (keypad_in == KEY_P1) || (keypad_in == KEY_P2);
    assign pl     = (keypad_in == KEY_P2);
    assign press  = key_valid && !kv_q && key_ok;

    always_comb begin
        score1_d = score1_q;
        score2_d = score2_q;
        if (right) begin
            if (!pl) score1_d = (score1_q == 3'd7) ? 3'd7 : score1_q + 3'd1;
            else     score2_d = (score2_q == 3'd7) ? 3'd7 : score2_q + 3'd1;
        end
`ifdef BELL_PENALTY_EN
        else begin
            if (!pl) score1_d = (score1_q == 3'd0) ? 3'd0 : score1_q - 3'd1;
            else     score2_d = (score2_q == 3'd0) ? 3'd0 : score2_q - 3'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            lfsr_q   <= SEED;
            ptr_q    <= 1'b0;
            kv_q     <= 1'b0;
            c1_q     <= 2'd0;
            c2_q     <= 2'd0;
            n1_q     <= 3'd0;
            n2_q     <= 3'd0;
            score1_q <= 3'd0;
            score2_q <= 3'd0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            who_q    <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            kv_q   <= key_valid;
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) state_q <= S_DEAL;
                end
                S_DEAL: begin
                    if (!ptr_q) begin
                        c1_q <= deal_c;
                        n1_q <= deal_n;
                    end else begin
                        c2_q <= deal_c;
                        n2_q <= deal_n;
                    end
                    ptr_q   <= ~ptr_q;
                    lfsr_q  <= {lfsr_q[6:0], fb};
                    timer_q <= TW'(WINDOW - 1);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (press) begin
                        who_q    <= pl;
                        score1_q <= score1_d;
                        score2_q <= score2_d;
                        if (right) begin
                            hit_q <= 1'b1;
                            c1_q  <= 2'd0;
                            c2_q  <= 2'd0;
                            n1_q  <= 3'd0;
                            n2_q  <= 3'd0;
                        end else begin
                            miss_q <= 1'b1;
                        end
                        timer_q <= TW'(GAP - 1);
                        state_q <= S_HOLD;
                    end else if (timer_q == '0) begin
                        state_q <= S_DEAL;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (timer_q == '0) begin
                        if (score1_q == 3'(WIN_SCORE) ||
                            score2_q == 3'(WIN_SCORE)) begin
                            over_q  <= 1'b1;
                            state_q <= S_OVER;
                        end else begin
                            state_q <= S_DEAL;
                        end
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                S_OVER: begin
                    if (start) begin
                        score1_q <= 3'd0;
                        score2_q <= 3'd0;
                        c1_q     <= 2'd0;
                        c2_q     <= 2'd0;
                        n1_q     <= 3'd0;
                        n2_q     <= 3'd0;
                        ptr_q    <= 1'b0;
                        over_q   <= 1'b0;
                        state_q  <= S_DEAL;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign c1        = c1_q;
    assign c2        = c2_q;
    assign n1        = n1_q;
    assign n2        = n2_q;
    assign score1    = score1_q;
    assign score2    = score2_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign who       = who_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_bell_round_ctrl.sv
// Bench for bell_round_ctrl: directed table, corner sequences and random rounds
// against a game-level reference model.
module tb_bell_round_ctrl;

    localparam int         W    = 32;
    localparam int         GAP  = 8;
    localparam int         WIN  = 5;
    localparam logic [7:0] SEED = 8'hA5;
    localparam logic [3:0] P1   = 4'b1001;
    localparam logic [3:0] P2   = 4'b0111;

    logic       clk = 1'b0;
    logic       rst, start, key_valid, load_en;
    logic [3:0] keypad_in;
    logic [1:0] load_c;
    logic [2:0] load_n;
    logic [1:0] c1, c2;
    logic [2:0] n1, n2, score1, score2;
    logic       hit, miss, who, game_over;

    bell_round_ctrl #(
        .WINDOW(W), .GAP(GAP), .WIN_SCORE(WIN), .SEED(SEED),
        .KEY_P1(P1), .KEY_P2(P2)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .keypad_in(keypad_in), .key_valid(key_valid),
        .load_en(load_en), .load_c(load_c), .load_n(load_n),
        .c1(c1), .c2(c2), .n1(n1), .n2(n2),
        .score1(score1), .score2(score2),
        .hit(hit), .miss(miss), .who(who), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Game-level model
    int m_c[2], m_n[2], m_s[2];
    int m_ptr, m_lfsr;
    bit m_hit, m_miss, m_who, m_go;

    typedef struct {
        int         c;
        int         n;
        int         k;
        logic [3:0] code;
        logic       hit;
        logic       miss;
        logic       who;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [19:0] exp_vec();
        return {2'(m_c[0]), 2'(m_c[1]), 3'(m_n[0]), 3'(m_n[1]),
                3'(m_s[0]), 3'(m_s[1]), m_hit, m_miss, m_who, m_go};
    endfunction

    function automatic logic [19:0] dut_vec();
        return {c1, c2, n1, n2, score1, score2, hit, miss, who, game_over};
    endfunction

    task automatic check_all(input string nm);
        chk(nm, {12'b0, dut_vec()}, {12'b0, exp_vec()});
    endtask

    task automatic m_reset();
        for (int s = 0; s < 2; s++) begin
            m_c[s] = 0; m_n[s] = 0; m_s[s] = 0;
        end
        m_ptr = 0; m_lfsr = int'(SEED);
        m_hit = 0; m_miss = 0; m_who = 0; m_go = 0;
    endtask

    task automatic mtick();
        @(posedge clk);
        #1;
        m_hit  = 0;
        m_miss = 0;
    endtask

    function automatic bit m_right();
        for (int f = 1; f <= 3; f++) begin
            int tot = 0;
            for (int s = 0; s < 2; s++)
                if (m_c[s] == f) tot += m_n[s];
            if (tot == 5) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic m_judge(input bit pl);
        m_who = pl;
        if (m_right()) begin
            m_hit = 1;
            if (m_s[pl] < 7) m_s[pl]++;
            for (int s = 0; s < 2; s++) begin
                m_c[s] = 0; m_n[s] = 0;
            end
        end else begin
            m_miss = 1;
`ifdef BELL_PENALTY_EN
            if (m_s[pl] > 0) m_s[pl]--;
`endif
        end
    endtask

    task automatic card_from(input int l, output int c, output int n);
        int raw;
        c   = l % 4;
        if (c == 0) c = 1;
        raw = (l / 4) % 8;
        if (raw == 0 || raw == 6) n = 1;
        else if (raw == 7)        n = 2;
        else                      n = raw;
    endtask

    task automatic do_deal(input bit dir, input int c, input int n);
        int cc, nn;
        load_en = dir;
        load_c  = 2'(c);
        load_n  = 3'(n);
        mtick();
        if (dir) begin
            cc = c; nn = n;
        end else begin
            card_from(m_lfsr, cc, nn);
        end
        m_c[m_ptr] = cc;
        m_n[m_ptr] = nn;
        m_ptr  = 1 - m_ptr;
        m_lfsr = ((m_lfsr * 2) | (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^
                 (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1)) & 255;
        load_en = 0;
        check_all("deal");
    endtask

    // k = WAIT edge carrying the press (1..W), 0 = let the window expire
    task automatic wait_round(input int k, input logic [3:0] code,
                              input int used);
        if (k == 0) begin
            for (int i = used; i < W; i++) begin
                mtick();
                check_all("wait");
            end
        end else begin
            for (int i = used; i < k - 1; i++) begin
                mtick();
                check_all("wait");
            end
            key_valid = 1;
            keypad_in = code;
            mtick();
            m_judge(code == P2);
            key_valid = 0;
            check_all("judge");
        end
    endtask

    task automatic hold_phase();
        for (int i = 0; i < GAP; i++) begin
            mtick();
            if (i == GAP - 1 && (m_s[0] == WIN || m_s[1] == WIN)) m_go = 1;
            check_all("hold");
        end
    endtask

    task automatic restart();
        for (int i = 0; i < 3; i++) begin
            key_valid = (i == 0);
            keypad_in = P1;
            mtick();
            check_all("over");
        end
        key_valid = 0;
        start = 1;
        mtick();
        start = 0;
        for (int s = 0; s < 2; s++) begin
            m_c[s] = 0; m_n[s] = 0; m_s[s] = 0;
        end
        m_ptr = 0;
        m_go  = 0;
        check_all("restart");
    endtask

    initial begin
        int k, c, n, f;
        bit dir;
        logic [3:0] code;

        tbl[0] = '{3, 5, 1, P1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{3, 4, 0, 4'h0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1, 1, 4, P1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1, 4, W, P2, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{2, 5, 5, P2, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{2, 3, 0, 4'h0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1, 5, 3, P1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{0, 5, 7, P2, 1'b0, 1'b1, 1'b1};
        tbl[8] = '{2, 6, 0, 4'h0, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{2, 7, 2, P1, 1'b0, 1'b1, 1'b0};

        rst = 0; start = 0; key_valid = 0; keypad_in = 4'h0;
        load_en = 0; load_c = 2'd0; load_n = 3'd0;
        m_reset();

        for (int i = 0; i < 3; i++) mtick();
        check_all("reset");
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            mtick();
            check_all("idle");
        end
        key_valid = 1; keypad_in = P1;
        mtick();
        check_all("idle_key");
        key_valid = 0;
        mtick();
        check_all("idle_key2");

        start = 1;
        mtick();
        start = 0;
        check_all("start");

        for (int r = 0; r < 10; r++) begin
            do_deal(1'b1, tbl[r].c, tbl[r].n);
            wait_round(tbl[r].k, tbl[r].code, 0);
            if (tbl[r].k != 0) begin
                chk($sformatf("tbl%0d_hmw", r), {29'b0, hit, miss, who},
                    {29'b0, tbl[r].hit, tbl[r].miss, tbl[r].who});
                hold_phase();
            end
        end

        // Code 0000 and a held strobe are both ignored in WAIT
        do_deal(1'b1, 3, 5);
        key_valid = 1; keypad_in = 4'b0000;
        mtick();
        check_all("code0");
        keypad_in = P1;
        for (int i = 0; i < 3; i++) begin
            mtick();
            check_all("held");
        end
        key_valid = 0;
        mtick();
        check_all("release");
        wait_round(6, P1, 5);
        for (int i = 0; i < GAP; i++) begin
            key_valid = (i != 1);
            keypad_in = P2;
            mtick();
            check_all("hold_key");
        end
        do_deal(1'b0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            mtick();
            check_all("held2");
        end
        key_valid = 0;
        wait_round(0, 4'h0, 2);

        for (int r = 0; r < 40; r++) begin
            dir  = 1'($urandom_range(0, 1));
            c    = int'($urandom_range(0, 3));
            n    = ($urandom_range(0, 1) == 1) ? 5 : int'($urandom_range(0, 7));
            do_deal(dir, c, n);
            k    = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, W));
            code = ($urandom_range(0, 1) == 1) ? P1 : P2;
            wait_round(k, code, 0);
            if (k != 0) begin
                hold_phase();
                if (m_go) restart();
            end
        end

        for (int g = 0; g < 2 * WIN + 2 && !m_go; g++) begin
            f = (m_c[1 - m_ptr] == 1) ? 2 : 1;
            do_deal(1'b1, f, 5);
            wait_round(1, P1, 0);
            hold_phase();
        end
        chk("game_over", {31'b0, game_over}, 32'd1);
        restart();
        do_deal(1'b0, 0, 0);

        for (int i = 0; i < 2; i++) begin
            mtick();
            check_all("wait_pre_rst");
        end
        rst = 0; key_valid = 1; keypad_in = P1;
        mtick();
        key_valid = 0;
        m_reset();
        check_all("rst_mid");
        mtick();
        rst = 1;
        start = 1;
        mtick();
        start = 0;
        check_all("rst_start");
        do_deal(1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bell_round_ctrl.md
Name: bell_round_ctrl

Overview:
- Sequences one round-based fruit-bell game.
- Deals cards into two display slots (fruit c1/c2, count n1/n2) and opens a timed response window after each deal.
- Takes bell presses from two players sharing the single keypad bus, judges each press with the "some fruit totals exactly 5" rule, and keeps per-player scores until one player reaches the win score.

Parameters:
- WINDOW, 32, response window length in cycles after each deal (>=2)
- GAP, 8, cycles spent in HOLD after a judged press (>=1)
- WIN_SCORE, 5, score that ends the game (1..7)
- SEED, 8'hA5, LFSR reset value (must be nonzero)
- KEY_P1, 4'b1001, keypad code of player 1's bell
- KEY_P2, 4'b0111, keypad code of player 2's bell

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active low (all state cleared on any rising clk edge where rst==0)
- start  in  1  level; leaves IDLE/OVER
- keypad_in  in  4  keypad code, meaningful only while key_valid==1
- key_valid  in  1  keypad strobe; a press is a 0->1 transition
- load_en  in  1  directed deal: use load_c/load_n instead of LFSR
- load_c  in  2  directed fruit (0 = empty)
- load_n  in  3  directed count
- c1, c2  out  2  slot fruit codes (0 = empty, 1..3 fruit)
- n1, n2  out  3  slot counts
- score1, score2  out  3  player scores
- hit  out  1  one-cycle pulse: correct press judged
- miss  out  1  one-cycle pulse: wrong press judged
- who  out  1  player of the last judged press (0 = P1, 1 = P2)
- game_over  out  1  high in OVER

Behaviour:
- Reset values:
  - all card outputs, scores, hit, miss, who, game_over = 0
  - state = IDLE, slot pointer = slot 1, LFSR = SEED, key_valid history = 0
- right (combinational, from the registered slots), true if any of:
  - (c1!=0 & c1==c2 & n1+n2==5), computed 4-bit
  - (c1!=0 & c1!=c2 & n1==5)
  - (c2!=0 & c2!=c1 & n2==5)
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4; advances once per DEAL.
  - fruit = lfsr[1:0], with 0 mapped to 1.
  - count: raw = lfsr[4:2]; 0 -> 1, 6 -> 1, 7 -> 2, else raw.
- press = key_valid & ~key_valid_q & (keypad_in==KEY_P1 | keypad_in==KEY_P2). Other codes and held strobes are ignored.
- FSM states: IDLE, DEAL, WAIT, HOLD, OVER.
- IDLE: start=1 -> DEAL.
- DEAL (1 cycle):
  - Writes the card to the slot addressed by the pointer (load_en selects directed values), then toggles the pointer.
  - Loads timer = WINDOW-1; -> WAIT.
- WAIT:
  - On press: who = player; if right, that player's score +1, hit=1, both slots cleared to 0; else miss=1. Either way -> HOLD.
  - Outputs update on the same edge that samples the press.
  - No press: if timer==0 -> DEAL, else timer-1.
  - Press and timer==0 on the same cycle: the press wins.
- HOLD:
  - Counts GAP cycles, ignores presses.
  - Then -> OVER if any score==WIN_SCORE, else -> DEAL.
- OVER:
  - game_over=1; cards frozen.
  - start=1 -> scores cleared, slots cleared, pointer = slot 1, -> DEAL. LFSR is not reseeded.
- Scores saturate at 7 and never wrap.
- A rst=0 mid-round aborts immediately to reset values, including in-flight hit/miss pulses.

Optional Feature:
- Macro: BELL_PENALTY_EN.
- Defined: a wrong press also decrements the presser's score, saturating at 0.
- Undefined: a wrong press only pulses miss and enters HOLD; scores are unchanged.

Test Plan:
- Reset/idle: rst=0 for 3 cycles, then rst=1 with start=0 -> all outputs 0; state stays IDLE; pressing KEY_P1 has no effect.
- Single-slot five, correct press:
  - Stimulus: start; directed deal c1=3 n1=5; P1 press (1001) in WAIT.
  - Response: hit pulse, who=0, score1=1, slots cleared; after GAP cycles a new DEAL.
- Cross-slot sum, correct press:
  - Stimulus: deals c1=1 n1=1, then c2=3 n2=4 (no press), then c1=3 n1=1; P2 press (0111).
  - Response: hit, who=1, score2=1.
- Wrong press and penalty:
  - Stimulus: c1=1 n1=1, c2=3 n2=4; P1 press.
  - Response: miss pulse, score1 unchanged (macro off) / decremented with floor 0 (macro on).
- Timeout and simultaneity:
  - No press for WINDOW cycles -> next DEAL into the other slot.
  - Press on the timer==0 cycle -> judged, not redealt.
  - Held key_valid -> counted once.
  - Code 0000 -> ignored.
- Game end and reset:
  - P1 reaches WIN_SCORE=5 -> OVER with game_over=1; start -> scores 0, new DEAL.
  - rst=0 asserted during WAIT -> all outputs 0 on the next edge.
